// File: rtl/slicer_offset_ctrl.sv
// slicer_offset_ctrl: frame-based automatic offset control for a variable slicer.
// Measures the peak required offset over each N-sample frame and moves the
// slicer window on frame boundaries (up immediately, down one step with
// hysteresis), with a manual override that always wins.
module slicer_offset_ctrl #(
  parameter int DATA_WIDTH   = 48,
  parameter int OUT_WIDTH    = 13,
  parameter int OFFSET_WIDTH = 6,
  parameter int OFFSET_MAX   = DATA_WIDTH - OUT_WIDTH
) (
  input  logic                    clk,
  input  logic                    async_reset_n,
  input  logic                    enable_i,
  input  logic                    manual_i,
  input  logic [OFFSET_WIDTH-1:0] manual_offset_i,
  input  logic [15:0]             frame_len_i,
  input  logic [OFFSET_WIDTH-1:0] hyst_i,
  input  logic                    valid_i,
  input  logic [DATA_WIDTH-1:0]   signal_i,
  output logic [OFFSET_WIDTH-1:0] slice_offset_o,
  output logic                    offset_update_o,
  output logic                    clip_o,
  output logic [OFFSET_WIDTH-1:0] peak_req_o
);

  localparam logic [OFFSET_WIDTH-1:0] OFF_MAX = OFFSET_WIDTH'(OFFSET_MAX);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                  state_q;
  logic [15:0]             cnt_q;
  logic [15:0]             len_q;
  logic [OFFSET_WIDTH-1:0] peak_q;

  logic [OFFSET_WIDTH-1:0] req;
  logic [OFFSET_WIDTH-1:0] peak_nxt;
  logic [OFFSET_WIDTH-1:0] man_off;
  logic [OFFSET_WIDTH-1:0] auto_off;
  logic [OFFSET_WIDTH-1:0] off_nxt;
  logic [OFFSET_WIDTH:0]   peak_plus_hyst;
  logic                    frame_done;

  // Offset needed so the sample's magnitude fits in the OUT_WIDTH window:
  // count significant bits below the sign, keep one for the sign itself.
  function automatic logic [OFFSET_WIDTH-1:0] calc_req(input logic [DATA_WIDTH-1:0] s);
    int h;
    int t;
    h = 0;
    for (int i = 0; i < DATA_WIDTH - 1; i++)
      if (s[i] != s[DATA_WIDTH-1]) h = i + 1;
    t = h + 1 - OUT_WIDTH;
    if (t < 0) t = 0;
    if (t > OFFSET_MAX) t = OFFSET_MAX;
    return OFFSET_WIDTH'(t);
  endfunction

  // Per-sample requirement, running peak and the frame-end offset decision.
  always_comb begin
    req            = calc_req(signal_i);
    peak_nxt       = (req > peak_q) ? req : peak_q;
    man_off        = (manual_offset_i > OFF_MAX) ? OFF_MAX : manual_offset_i;
    peak_plus_hyst = {1'b0, peak_nxt} + {1'b0, hyst_i};
    frame_done     = (state_q == ACCUM) && enable_i && valid_i && (cnt_q == len_q);
    // The decrement branch implies slice_offset_o >= 1, so it never wraps.
    if (peak_nxt > slice_offset_o)
      auto_off = peak_nxt;
    else if (peak_plus_hyst < {1'b0, slice_offset_o})
      auto_off = slice_offset_o - 1'b1;
    else
      auto_off = slice_offset_o;
    if (manual_i)
      off_nxt = man_off;
    else if (frame_done)
      auto_off_sel: off_nxt = auto_off;
    else
      off_nxt = slice_offset_o;
  end

  // Frame FSM with registered outputs; the offset register is shared by the
  // manual and automatic paths so the update pulse covers both.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      len_q           <= '0;
      peak_q          <= '0;
      slice_offset_o  <= '0;
      offset_update_o <= 1'b0;
      clip_o          <= 1'b0;
      peak_req_o      <= '0;
    end else begin
      slice_offset_o  <= off_nxt;
      offset_update_o <= (off_nxt != slice_offset_o);
      clip_o          <= valid_i && (req > slice_offset_o);
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          peak_q <= '0;
          if (enable_i) begin
            state_q <= ACCUM;
            len_q   <= frame_len_i;
          end
        end
        ACCUM: begin
          if (!enable_i) begin
            // Partial frame is dropped without touching the offset.
            state_q <= IDLE;
            cnt_q   <= '0;
            peak_q  <= '0;
          end else if (valid_i) begin
            if (cnt_q == len_q) begin
              peak_req_o <= peak_nxt;
              cnt_q      <= '0;
              peak_q     <= '0;
              len_q      <= frame_len_i;
            end else begin
              cnt_q  <= cnt_q + 16'd1;
              peak_q <= peak_nxt;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slicer_offset_ctrl.sv
// Directed bench for slicer_offset_ctrl: hand-computed offsets, pulses and peaks.
module tb_slicer_offset_ctrl;

  logic        clk = 1'b0;
  logic        async_reset_n;
  logic        enable_i;
  logic        manual_i;
  logic [5:0]  manual_offset_i;
  logic [15:0] frame_len_i;
  logic [5:0]  hyst_i;
  logic        valid_i;
  logic [47:0] signal_i;
  logic [5:0]  slice_offset_o;
  logic        offset_update_o;
  logic        clip_o;
  logic [5:0]  peak_req_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  slicer_offset_ctrl dut (
    .clk             (clk),
    .async_reset_n   (async_reset_n),
    .enable_i        (enable_i),
    .manual_i        (manual_i),
    .manual_offset_i (manual_offset_i),
    .frame_len_i     (frame_len_i),
    .hyst_i          (hyst_i),
    .valid_i         (valid_i),
    .signal_i        (signal_i),
    .slice_offset_o  (slice_offset_o),
    .offset_update_o (offset_update_o),
    .clip_o          (clip_o),
    .peak_req_o      (peak_req_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [47:0] d);
    valid_i  = 1'b1;
    signal_i = d;
    tick();
    valid_i  = 1'b0;
    signal_i = '0;
  endtask

  task automatic chk_out(input string tag, input logic [5:0] off, input logic upd,
                         input logic [5:0] pk);
    chk({tag, ".off"}, 64'(slice_offset_o), 64'(off));
    chk({tag, ".upd"}, 64'(offset_update_o), 64'(upd));
    chk({tag, ".pk"},  64'(peak_req_o), 64'(pk));
  endtask

  initial begin
    async_reset_n   = 1'b0;
    enable_i        = 1'b0;
    manual_i        = 1'b0;
    manual_offset_i = '0;
    frame_len_i     = 16'd3;
    hyst_i          = '0;
    valid_i         = 1'b0;
    signal_i        = '0;
    tick(); tick();
    chk_out("rst", 6'd0, 1'b0, 6'd0);
    chk("rst.clip", 64'(clip_o), 64'd0);

    // Sign handling: -4096 fits the window, -4097 needs offset 1.
    async_reset_n = 1'b1;
    enable_i      = 1'b1;
    tick();
    send(48'hFFFF_FFFF_F000); chk("neg4096.clip", 64'(clip_o), 64'd0);
    send(48'hFFFF_FFFF_EFFF); chk("neg4097.clip", 64'(clip_o), 64'd1);
    send(48'h0);              chk("neg.clip0", 64'(clip_o), 64'd0);
    chk("neg.hold", 64'(slice_offset_o), 64'd0);
    send(48'h0);              chk_out("neg.end", 6'd1, 1'b1, 6'd1);
    tick();                   chk("neg.upd_off", 64'(offset_update_o), 64'd0);

    // Async reset mid-frame: clip is high, then clears without a clock edge.
    send(48'h1_0000);         chk("pre_rst.clip", 64'(clip_o), 64'd1);
    #2 async_reset_n = 1'b0;
    #1;
    chk_out("async_rst", 6'd0, 1'b0, 6'd0);
    chk("async_rst.clip", 64'(clip_o), 64'd0);
    tick();
    async_reset_n = 1'b1;
    tick();

    // Rise: frame of four, second sample clips, offset 0->1 only at the end.
    send(48'h0000_0000_0FFF); chk("rise.s1.clip", 64'(clip_o), 64'd0);
    send(48'h0000_0000_1000); chk("rise.s2.clip", 64'(clip_o), 64'd1);
    send(48'h0);              chk("rise.s3.off", 64'(slice_offset_o), 64'd0);
    frame_len_i = 16'd0;      // relatched at this frame's end: N=1 afterwards
    send(48'h0);              chk_out("rise.end", 6'd1, 1'b1, 6'd1);
    tick();                   chk("rise.upd_off", 64'(offset_update_o), 64'd0);

    // Decay: jump to 5, then one-frame-per-sample steps with hysteresis.
    send(48'h1_0000);         chk_out("decay.up5", 6'd5, 1'b1, 6'd5);
    hyst_i = 6'd2;
    send(48'h4000);           chk_out("decay.p3", 6'd5, 1'b0, 6'd3);
    send(48'h2000);           chk_out("decay.p2", 6'd4, 1'b1, 6'd2);
    send(48'h0);              chk_out("decay.z1", 6'd3, 1'b1, 6'd0);
    send(48'h0);              chk_out("decay.z2", 6'd2, 1'b1, 6'd0);
    // With hyst 2 a zero peak cannot pull offset 2 lower (0+2 is not < 2).
    send(48'h0);              chk_out("decay.z3", 6'd2, 1'b0, 6'd0);
    hyst_i = 6'd0;
    send(48'h0);              chk_out("decay.z4", 6'd1, 1'b1, 6'd0);
    send(48'h0);              chk_out("decay.z5", 6'd0, 1'b1, 6'd0);
    send(48'h0);              chk_out("decay.floor", 6'd0, 1'b0, 6'd0);

    // Manual override clamps to 35; frames complete but offset is pinned.
    manual_i        = 1'b1;
    manual_offset_i = 6'd40;
    tick();                   chk_out("man.clamp", 6'd35, 1'b1, 6'd0);
    tick();                   chk("man.upd_off", 64'(offset_update_o), 64'd0);
    send(48'h10_0000);        chk_out("man.p9", 6'd35, 1'b0, 6'd9);
    send(48'h0);              chk_out("man.p0", 6'd35, 1'b0, 6'd0);
    manual_offset_i = 6'd3;
    tick();                   chk_out("man.3", 6'd3, 1'b1, 6'd0);
    manual_i = 1'b0;
    tick();                   chk_out("man.rel", 6'd3, 1'b0, 6'd0);

    // One-sample frame decays 3->2 and relatches N=4.
    frame_len_i = 16'd3;
    send(48'h0);              chk_out("len4.latch", 6'd2, 1'b1, 6'd0);

    // Abort after two samples, then a full frame counted from zero.
    send(48'h1_0000);         chk("abort.s1.clip", 64'(clip_o), 64'd1);
    send(48'h1_0000);
    enable_i = 1'b0;
    tick();                   chk_out("abort", 6'd2, 1'b0, 6'd0);
    enable_i = 1'b1;
    tick();
    send(48'h4000);
    send(48'h0);
    send(48'h0);              chk("abort.s3.off", 64'(slice_offset_o), 64'd2);
    send(48'h0);              chk_out("abort.full", 6'd3, 1'b1, 6'd3);

    // Enable drop coinciding with the last sample suppresses the update.
    send(48'h1_0000);
    send(48'h0);
    send(48'h0);
    enable_i = 1'b0;
    send(48'h1_0000);         chk_out("drop_last", 6'd3, 1'b0, 6'd3);

    // Saturation: full-scale positive sample needs the maximum offset 35.
    frame_len_i = 16'd0;
    enable_i    = 1'b1;
    tick();
    send(48'h7FFF_FFFF_FFFF); chk_out("sat", 6'd35, 1'b1, 6'd35);
    chk("sat.clip", 64'(clip_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
